accumulator_16bit: RTL and testbench

ACCUMULATOR_16BIT -- requirements
Module: accumulator_16bit

---
 rtl/accumulator_16bit_pkg.sv | 13 +
 rtl/accumulator_16bit_rca.sv | 21 ++
 rtl/accumulator_16bit.sv | 117 +++++++++++
 tb/tb_accumulator_16bit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/accumulator_16bit_pkg.sv
// Shared constants and state encoding for the 16-bit job accumulator.
package accumulator_16bit_pkg;

    localparam int DATA_W      = 16;
    localparam int MAX_OPS_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/accumulator_16bit_rca.sv
// 16-bit ripple-carry adder built from a chain of full-adder cells.
module Ripple_Carry_Addr_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    output logic [15:0] S,
    output logic        cout
);

    logic [16:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign S[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign cout = w_c[16];

endmodule

// File: rtl/accumulator_16bit.sv
// Job-based accumulator: sums num_ops operands via a ripple-carry adder,
// tracks sticky carry-out, and presents the result with a valid/ready handshake.
module accumulator_16bit
    import accumulator_16bit_pkg::*;
#(
    parameter int MAX_OPS = MAX_OPS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        num_ops,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              overflow
);

    localparam logic [3:0] MAX_OPS_4 = 4'(MAX_OPS);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_acc;
    logic              r_ovf;
    logic [3:0]        r_rem;

    logic [DATA_W-1:0] w_sum;
    logic              w_cout;
    logic              w_accept;
    logic [3:0]        w_ops_clamped;

    Ripple_Carry_Addr_16bit u_rca (
        .A    (r_acc),
        .B    (in_data),
        .cin  (1'b0),
        .S    (w_sum),
        .cout (w_cout)
    );

    assign w_accept      = in_valid & in_ready;
    assign w_ops_clamped = (num_ops > MAX_OPS_4) ? MAX_OPS_4 : num_ops;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (num_ops == 4'd0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept && (r_rem == 4'd1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs depend on state only, never on in_valid.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            ST_IDLE:  ;
            ST_ACCUM: in_ready  = 1'b1;
            ST_DONE:  out_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_rem <= 4'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        r_rem <= w_ops_clamped;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_cout;
                        r_rem <= r_rem - 4'd1;
                    end
                end
                ST_DONE: ;
                default: ;
            endcase
        end
    end

    assign sum      = r_acc;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_accumulator_16bit.sv
// Directed self-checking bench for accumulator_16bit.
module tb_accumulator_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_ops;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    accumulator_16bit #(.MAX_OPS(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_ops   (num_ops),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [3:0] n);
        start   = 1'b1;
        num_ops = n;
        tick();
        start   = 1'b0;
        num_ops = 4'd0;
    endtask

    // Present one operand; it is accepted on the next edge.
    task automatic send(input string tag, input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_no_valid_yet"}, 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic result(input string tag, input logic [15:0] es,
                          input logic eo);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, 32'(out_valid), 32'd0);
        chk({tag, "_kept"}, 32'(sum), 32'(es));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        num_ops   = 4'd3;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b1;
        tick();
        tick();
        start     = 1'b0;
        num_ops   = 4'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        start_job(4'd2);
        send("t1a", 16'd414);
        send("t1b", 16'd1036);
        result("t1", 16'd1450, 1'b0);

        // Zero-operand job clears the retained sum and waits on out_ready.
        start_job(4'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            start   = 1'b1;
            num_ops = 4'd3;
            tick();
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_sum", 32'(sum), 32'd0);
            chk("t4_hold_ovf", 32'(overflow), 32'd0);
        end
        start   = 1'b0;
        num_ops = 4'd0;
        result("t4", 16'd0, 1'b0);

        start_job(4'd2);
        send("t2a", 16'd5045);
        send("t2b", 16'd45042);
        result("t2", 16'd50087, 1'b0);

        start_job(4'd2);
        send("t2c", 16'd32768);
        send("t2d", 16'd32768);
        result("t2x", 16'd0, 1'b1);

        start_job(4'd3);
        send("t3a", 16'd65535);
        chk("t3_ovf_first", 32'(overflow), 32'd0);
        send("t3b", 16'd65535);
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        chk("t3_mid_sum", 32'(sum), 32'd65534);
        send("t3c", 16'd2);
        result("t3", 16'd0, 1'b1);

        // Gaps with junk data and stray start pulses must not disturb the job.
        start_job(4'd4);
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
        send("t5a", 16'd100);
        in_data = 16'hFFFF;
        start   = 1'b1;
        num_ops = 4'd1;
        tick();
        tick();
        start   = 1'b0;
        chk("t5_gap_ready", 32'(in_ready), 32'd1);
        chk("t5_gap_sum", 32'(sum), 32'd100);
        send("t5b", 16'd200);
        start = 1'b1;
        tick();
        start = 1'b0;
        send("t5c", 16'd300);
        tick();
        tick();
        chk("t5_gap2_valid", 32'(out_valid), 32'd0);
        send("t5d", 16'd400);
        result("t5", 16'd1000, 1'b0);

        start_job(4'd4);
        send("t6a", 16'd10);
        send("t6b", 16'd20);
        rst       = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd30;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_sum", 32'(sum), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        tick();
        chk("t6_still_idle", 32'(in_ready), 32'd0);
        start_job(4'd1);
        send("t6c", 16'd7);
        result("t6", 16'd7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
